// File: rtl/tile_spawn_ctrl.sv
// tile_spawn_ctrl: places a new tile on the 2048 board after each completed move.
// It picks a random cell and retries a bounded number of times on occupied
// cells. If every pick misses, it scans the board linearly for a free cell.
// The chosen cell is offered over a valid/ack handshake. When no cell is free,
// game over is flagged and held.
// Optional build macro: SPAWN_INIT_EN. When defined, two automatic spawns run
// after reset release and after every new_game_i.
module tile_spawn_ctrl #(
    parameter int N_CELLS     = 16,
    parameter int IDX_W       = 4,
    parameter int RAND_W      = 12,
    parameter int MAX_TRIES   = 4,
    parameter int FOUR_THRESH = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               move_done_i,
    input  logic               new_game_i,
    input  logic [N_CELLS-1:0] occ_i,
    input  logic [RAND_W-1:0]  rand_in_i,
    input  logic               spawn_ack_i,
    output logic               spawn_valid_o,
    output logic [IDX_W-1:0]   spawn_idx_o,
    output logic               spawn_four_o,
    output logic               busy_o,
    output logic               game_over_o,
    output logic               drop_err_o,
    output logic [15:0]        spawn_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_SCAN,
        ST_OFFER,
        ST_FULL
    } state_t;

    localparam logic [3:0] LAST_TRY    = 4'(MAX_TRIES - 1);
    localparam logic [7:0] THRESH_BYTE = 8'(FOUR_THRESH);

    state_t             state_q, state_d;
    logic [N_CELLS-1:0] occ_r_q, occ_r_d;
    logic [3:0]         tries_q, tries_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               four_q, four_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               drop_q, drop_d;
    logic               idle_ready;

    // Cell candidate and 2-vs-4 decision for this cycle's random word.
    logic [IDX_W-1:0] cand;
    logic             four_pick;
    assign cand      = rand_in_i[IDX_W-1:0];
    assign four_pick = (rand_in_i[IDX_W+7:IDX_W] < THRESH_BYTE);

`ifdef SPAWN_INIT_EN
    // Automatic spawns still owed after reset release or a new game.
    logic [1:0] init_q, init_d;
    assign idle_ready = (state_q == ST_IDLE) && (init_q == 2'd0);
`else
    assign idle_ready = (state_q == ST_IDLE);
`endif

    // Next-state, datapath and handshake decisions.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d = state_q;
        occ_r_d = occ_r_q;
        tries_d = tries_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        four_d  = four_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
`ifdef SPAWN_INIT_EN
        init_d  = init_q;
`endif
        if (new_game_i) begin
            // new_game wins over move_done and never reports a drop.
            state_d = ST_IDLE;
            occ_r_d = '0;
            tries_d = '0;
            ptr_d   = '0;
`ifdef SPAWN_INIT_EN
            init_d  = 2'd2;
`endif
        end else begin
            if (move_done_i && !idle_ready) begin
                drop_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
`ifdef SPAWN_INIT_EN
                    if (init_q != 2'd0) begin
                        // Init spawns reuse occ_r, so the second one avoids the first.
                        state_d = ST_PICK;
                        tries_d = '0;
                        init_d  = init_q - 2'd1;
                    end else
`endif
                    if (move_done_i) begin
                        occ_r_d = occ_i;
                        tries_d = '0;
                        state_d = (&occ_i) ? ST_FULL : ST_PICK;
                    end
                end
                ST_PICK: begin
                    if (!occ_r_q[cand]) begin
                        idx_d   = cand;
                        four_d  = four_pick;
                        state_d = ST_OFFER;
                    end else if (tries_q == LAST_TRY) begin
                        ptr_d   = '0;
                        state_d = ST_SCAN;
                    end else begin
                        tries_d = tries_q + 4'd1;
                    end
                end
                ST_SCAN: begin
                    // The board is known to have a free cell, so ptr never wraps.
                    if (!occ_r_q[ptr_q]) begin
                        idx_d   = ptr_q;
                        four_d  = four_pick;
                        state_d = ST_OFFER;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (spawn_ack_i) begin
                        occ_r_d[idx_q] = 1'b1;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        state_d = ST_IDLE;
                    end
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all
            // registers update together from the same pre-edge values.
            state_q <= state_d;
        end
    end

    // Datapath registers: occupancy copy, counters, offered tile, status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: occ_r is a plain 16-bit register and not a memory, so it
            // is reset with everything else to give a defined empty board.
            occ_r_q <= '0;
            tries_q <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            four_q  <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
`ifdef SPAWN_INIT_EN
            init_q  <= 2'd2;
`endif
        end else begin
            occ_r_q <= occ_r_d;
            tries_q <= tries_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            four_q  <= four_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
`ifdef SPAWN_INIT_EN
            init_q  <= init_d;
`endif
        end
    end

    assign spawn_valid_o = (state_q == ST_OFFER);
    assign spawn_idx_o   = idx_q;
    assign spawn_four_o  = four_q;
    assign busy_o        = (state_q == ST_PICK) || (state_q == ST_SCAN) || (state_q == ST_OFFER);
    assign game_over_o   = (state_q == ST_FULL);
    assign drop_err_o    = drop_q;
    assign spawn_cnt_o   = cnt_q;

endmodule

// File: tb/tb_tile_spawn_ctrl.sv
// Self-checking bench for tile_spawn_ctrl. The bench computes the expected
// offers from the board and random word it drives. It queues each expected
// offer and compares it when spawn_valid rises.
module tb_tile_spawn_ctrl;

    localparam int MAX_TRIES   = 4;
    localparam int FOUR_THRESH = 26;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_done, new_game, spawn_ack;
    logic [15:0] occ;
    logic [11:0] rand_in;
    logic        spawn_valid, spawn_four, busy, game_over, drop_err;
    logic [3:0]  spawn_idx;
    logic [15:0] spawn_cnt;

    tile_spawn_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .move_done_i   (move_done),
        .new_game_i    (new_game),
        .occ_i         (occ),
        .rand_in_i     (rand_in),
        .spawn_ack_i   (spawn_ack),
        .spawn_valid_o (spawn_valid),
        .spawn_idx_o   (spawn_idx),
        .spawn_four_o  (spawn_four),
        .busy_o        (busy),
        .game_over_o   (game_over),
        .drop_err_o    (drop_err),
        .spawn_cnt_o   (spawn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx;
        logic       four;
        int         lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_cnt  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for an offer; cyc counts cycles since move_done was sampled.
    task automatic wait_offer(input int start, output int cyc);
        cyc = start;
        while (!spawn_valid && cyc < 64) begin
            step();
            cyc++;
        end
        check("offer_seen", spawn_valid, 1);
    endtask

    task automatic ack_offer();
        spawn_ack = 1'b1;
        step();
        spawn_ack = 1'b0;
        if (exp_cnt != 16'hFFFF) exp_cnt++;
        check("ack_valid_low", spawn_valid, 0);
        check("ack_idle", busy, 0);
        check("ack_cnt", spawn_cnt, exp_cnt);
    endtask

    // Drive one move with a constant random word, then check the offer.
    task automatic do_spawn(input logic [15:0] b, input logic [11:0] r,
                            input int hold, input int drop_at);
        exp_t       e;
        int         cyc;
        int         f;
        logic [3:0] c;
        c      = r[3:0];
        e.four = (r[11:4] < 8'(FOUR_THRESH));
        if (!b[c]) begin
            e.idx = c;
            e.lat = 2;
        end else begin
            f = 0;
            while (b[f]) f++;
            e.idx = 4'(f);
            e.lat = 2 + MAX_TRIES + f;
        end
        sb_q.push_back(e);
        occ       = b;
        rand_in   = r;
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        check("busy_start", busy, 1);
        wait_offer(1, cyc);
        e = sb_q.pop_front();
        check("latency", cyc, e.lat);
        check("idx", spawn_idx, e.idx);
        check("four", spawn_four, e.four);
        for (int h = 0; h < hold; h++) begin
            rand_in = 12'($urandom);
            if (h == drop_at) move_done = 1'b1;
            step();
            move_done = 1'b0;
            check("hold_valid", spawn_valid, 1);
            check("hold_idx", spawn_idx, e.idx);
            check("hold_four", spawn_four, e.four);
            if (h == drop_at) check("drop_pulse", drop_err, 1);
            else check("drop_quiet", drop_err, 0);
        end
        ack_offer();
    endtask

    // Two automatic spawns in the init build; nothing to do otherwise.
    task automatic handle_init();
`ifdef SPAWN_INIT_EN
        int         cyc;
        logic [3:0] first_idx;
        wait_offer(0, cyc);
        first_idx = spawn_idx;
        ack_offer();
        wait_offer(0, cyc);
        check("init_distinct", (spawn_idx != first_idx), 1);
        ack_offer();
`endif
    endtask

    initial begin
        rst       = 1'b1;
        move_done = 1'b0;
        new_game  = 1'b0;
        spawn_ack = 1'b0;
        occ       = '0;
        rand_in   = '0;
        repeat (3) step();
        check("rst_valid", spawn_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_gameover", game_over, 0);
        check("rst_cnt", spawn_cnt, 0);
        check("rst_drop", drop_err, 0);
        rst = 1'b0;
        handle_init();

        // T1: first-try hit, ack in the first valid cycle.
        do_spawn(16'h0000, 12'h053, 0, -1);
        // Threshold boundary: byte 0x19 gives a 4, byte 0x1A gives a 2.
        do_spawn(16'h0000, 12'h199, 0, -1);
        do_spawn(16'h0000, 12'h1A7, 0, -1);
        do_spawn(16'h00FF, 12'h18C, 1, -1);
        // All picks miss, then the scan finds cell 0 immediately.
        do_spawn(16'h0008, 12'hA33, 0, -1);
        // T2: worst case, where only the last cell is free.
        do_spawn(16'h7FFF, 12'hFF5, 0, -1);
        // T4: ack held off while rand toggles; move_done during the wait.
        do_spawn(16'h1234, 12'h3C9, 10, 4);

        // T3: full board.
        occ       = 16'hFFFF;
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        check("full_gameover", game_over, 1);
        check("full_busy", busy, 0);
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        check("full_drop", drop_err, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("full_no_offer", spawn_valid, 0);
            check("full_hold", game_over, 1);
        end
        new_game  = 1'b1;
        move_done = 1'b1;
        step();
        new_game  = 1'b0;
        move_done = 1'b0;
        check("ng_gameover", game_over, 0);
        check("ng_no_drop", drop_err, 0);
        check("ng_cnt_kept", spawn_cnt, exp_cnt);
`ifndef SPAWN_INIT_EN
        check("ng_busy", busy, 0);
        step();
        check("ng_stays_idle", busy, 0);
`endif
        handle_init();
        do_spawn(16'h8001, 12'h2F0, 0, -1);

        // T5: async reset in the middle of a scan.
        occ       = 16'h7FFF;
        rand_in   = 12'hFF5;
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        repeat (7) step();
        check("scan_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", spawn_valid, 0);
        check("arst_idx", spawn_idx, 0);
        check("arst_cnt", spawn_cnt, 0);
        check("arst_gameover", game_over, 0);
        exp_cnt = '0;
        step();
        step();
        rst = 1'b0;
`ifdef SPAWN_INIT_EN
        handle_init();
`else
        for (int i = 0; i < 25; i++) begin
            step();
            check("post_rst_no_offer", spawn_valid, 0);
        end
`endif
        do_spawn(16'h0000, 12'h0E2, 2, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
